// File: rtl/phase_strobe_pkg.sv
// rtl/phase_strobe_pkg.sv - shared types and defaults for the phase strobe scheduler
package phase_strobe_pkg;

    localparam int NPH_DEFAULT  = 4;
    localparam int DIVW_DEFAULT = 8;
    localparam int IDXW         = $clog2(NPH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

endpackage

// File: rtl/phase_strobe_sched_if.sv
// rtl/phase_strobe_sched_if.sv - config, control and phase-output bundle of the scheduler
interface phase_strobe_sched_if
    import phase_strobe_pkg::*;
#(
    parameter int NPH  = NPH_DEFAULT,
    parameter int DIVW = DIVW_DEFAULT
);
    localparam int IW = $clog2(NPH);

    logic            cfg_valid;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_ready;
    logic            start;
    logic            stop;
    logic            busy;
    logic [NPH-1:0]  phase;
    logic [IW-1:0]   phase_idx;
    logic            strobe;
    logic            wrap;

    modport master (
        output cfg_valid, cfg_div, start, stop,
        input  cfg_ready, busy, phase, phase_idx, strobe, wrap
    );

    modport slave (
        input  cfg_valid, cfg_div, start, stop,
        output cfg_ready, busy, phase, phase_idx, strobe, wrap
    );

endinterface

// File: rtl/phase_prescaler.sv
// rtl/phase_prescaler.sv - dwell counter with clear, enable and terminal-count flag
module phase_prescaler #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    output logic            tc_o
);

    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;

    // Equality compare only: the count never passes div_i, so it cannot overflow.
    assign tc_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_strobe_sched.sv
// rtl/phase_strobe_sched.sv - single-clock 1-of-NPH phase sequencer producing enables and strobes
module phase_strobe_sched
    import phase_strobe_pkg::*;
#(
    parameter int NPH  = NPH_DEFAULT,
    parameter int DIVW = DIVW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    phase_strobe_sched_if.slave  bus
);

    localparam int            IW       = $clog2(NPH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPH - 1);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_RUN      = ST_RUN;
    localparam logic [1:0] S_STOPPING = ST_STOPPING;

    logic [1:0]      state_q,  state_d;
    logic [DIVW-1:0] div_q,    div_d;
    logic [NPH-1:0]  phase_q,  phase_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic            strobe_q, strobe_d;
    logic            wrap_q,   wrap_d;

    logic running;
    logic pre_tc;
    logic terminal;
    logic last_term;

    assign running   = (state_q != S_IDLE);
    assign terminal  = running & pre_tc;
    assign last_term = terminal & (idx_q == LAST_IDX);

    // Held cleared while idle so the entry cycle of a run always starts a fresh dwell.
    phase_prescaler #(
        .DIVW (DIVW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr_i (~running),
        .en_i  (running),
        .div_i (div_q),
        .tc_o  (pre_tc)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        wrap_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    div_d = bus.cfg_div;
                end
                if (bus.start && !bus.stop) begin
                    state_d  = S_RUN;
                    phase_d  = NPH'(1);
                    idx_d    = '0;
                    strobe_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = last_term ? S_IDLE : S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (last_term) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                idx_d   = '0;
            end
        endcase

        if (running) begin
            if (state_d == S_IDLE) begin
                phase_d = '0;
                idx_d   = '0;
            end else if (terminal) begin
                phase_d  = {phase_q[NPH-2:0], phase_q[NPH-1]};
                idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                strobe_d = 1'b1;
                wrap_d   = (idx_q == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            phase_q  <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.busy      = running;
    assign bus.cfg_ready = ~running;
    assign bus.phase     = phase_q;
    assign bus.phase_idx = idx_q;
    assign bus.strobe    = strobe_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_phase_strobe_sched.sv
// tb/tb_phase_strobe_sched.sv - randomized and directed bench against a frame-arithmetic model
module tb_phase_strobe_sched;
    import phase_strobe_pkg::*;

    localparam int NPH  = 4;
    localparam int DIVW = 8;

    logic clk = 1'b0;
    logic reset;

    phase_strobe_sched_if #(.NPH(NPH), .DIVW(DIVW)) bus ();

    phase_strobe_sched #(.NPH(NPH), .DIVW(DIVW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: mode 0 idle, 1 run, 2 stopping; m_t counts cycles since the run started.
    int m_mode = 0;
    int m_div  = 0;
    int m_t    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int m_idx();
        return (m_t / (m_div + 1)) % NPH;
    endfunction

    task automatic model_step();
        bit last_term;
        if (m_mode == 0) begin
            if (bus.cfg_valid) m_div = int'(bus.cfg_div);
            if (bus.start && !bus.stop) begin
                m_mode = 1;
                m_t    = 0;
            end
        end else begin
            last_term = (((m_t + 1) % (m_div + 1)) == 0) && (m_idx() == NPH - 1);
            if (last_term && (m_mode == 2 || bus.stop)) begin
                m_mode = 0;
            end else begin
                if (m_mode == 1 && bus.stop) m_mode = 2;
                m_t++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NPH-1:0] e_phase;
        int  e_idx;
        bit  e_strobe;
        bit  e_wrap;
        if (m_mode == 0) begin
            e_phase = '0; e_idx = 0; e_strobe = 0; e_wrap = 0;
        end else begin
            e_idx    = m_idx();
            e_phase  = NPH'(1) << e_idx;
            e_strobe = (m_t % (m_div + 1)) == 0;
            e_wrap   = e_strobe && (e_idx == 0) && (m_t > 0);
        end
        chk("phase",     32'(bus.phase),     32'(e_phase));
        chk("phase_idx", 32'(bus.phase_idx), 32'(e_idx));
        chk("strobe",    32'(bus.strobe),    32'(e_strobe));
        chk("wrap",      32'(bus.wrap),      32'(e_wrap));
        chk("busy",      32'(bus.busy),      32'(m_mode != 0));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_mode == 0));
    endtask

    task automatic cycle(input bit cv, input int cd, input bit st, input bit sp);
        logic [31:0] cdv;
        cdv           = cd;
        bus.cfg_valid = cv;
        bus.cfg_div   = cdv[DIVW-1:0];
        bus.start     = st;
        bus.stop      = sp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) break;
            cycle(0, 0, 0, 0);
        end
        chk("reach_idle", 32'(bus.busy), 32'd0);
    endtask

    // Called right after a negedge check: reset lands between edges and spans one posedge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("areset_phase",  32'(bus.phase),  32'd0);
        chk("areset_strobe", 32'(bus.strobe), 32'd0);
        chk("areset_busy",   32'(bus.busy),   32'd0);
        m_mode = 0; m_div = 0; m_t = 0;
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        @(negedge clk);
        check_outputs();

        // div 3, full frame and wrap back to phase 0
        cycle(1, 3, 0, 0);
        cycle(0, 0, 1, 0);
        idle_cycles(16);
        chk("wrap_at_16", 32'(bus.wrap),  32'd1);
        chk("phase_at_16", 32'(bus.phase), 32'd1);
        cycle(0, 0, 0, 1);
        run_until_idle(40);

        // div 0, continuous strobe, stop in phase 0010
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("div0_phase1", 32'(bus.phase), 32'h2);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("div0_stopped", 32'(bus.phase), 32'd0);
        run_until_idle(8);

        // div 2, stop in the terminal cycle of the last phase
        cycle(1, 2, 0, 0);
        cycle(0, 0, 1, 0);
        idle_cycles(11);
        chk("last_term_phase", 32'(bus.phase), 32'h8);
        cycle(0, 0, 0, 1);
        chk("stop_last_phase", 32'(bus.phase), 32'd0);
        chk("stop_last_wrap",  32'(bus.wrap),  32'd0);

        // cfg with start in the same cycle, then cfg ignored while running
        cycle(1, 5, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
        chk("dwell6_hold", 32'(bus.phase), 32'h1);
        cycle(1, 1, 0, 0);
        chk("dwell6_next", 32'(bus.phase), 32'h2);
        cycle(0, 0, 0, 1);
        run_until_idle(40);

        // start+stop together in idle, then start held through a run
        cycle(0, 0, 1, 1);
        chk("startstop_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        run_until_idle(40);

        // async reset mid-phase 0100
        cycle(1, 3, 0, 0);
        cycle(0, 0, 1, 0);
        idle_cycles(9);
        chk("pre_reset_phase", 32'(bus.phase), 32'h4);
        async_reset();
        cycle(0, 0, 1, 0);
        idle_cycles(5);
        cycle(0, 0, 0, 1);
        run_until_idle(8);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit cv, st, sp;
            int cd;
            cv = ($urandom % 4) == 0;
            cd = (($urandom % 30) == 0) ? int'($urandom_range(20, 255)) : int'($urandom_range(0, 4));
            st = ($urandom % 6) == 0;
            sp = ($urandom % 12) == 0;
            if (($urandom % 400) == 0) async_reset();
            else cycle(cv, cd, st, sp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
